// File: rtl/rb_bus_arbiter_if.sv
// Generic register-block bus shared by the two requesters, the arbiter and the register block.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface rb_bus_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          m0_rd_en;
    logic          m0_wr_en;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;
    logic          m0_err;

    logic          m1_rd_en;
    logic          m1_wr_en;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;
    logic          m1_err;

    logic          rd_en;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rack;
    logic          raddrerr;
    logic          wr_en;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wack;
    logic          waddrerr;

    logic          grant_id;
    logic          busy;

    modport slave (
        input  m0_rd_en, m0_wr_en, m0_addr, m0_wdata,
        output m0_rdata, m0_ack, m0_err,
        input  m1_rd_en, m1_wr_en, m1_addr, m1_wdata,
        output m1_rdata, m1_ack, m1_err,
        output rd_en, raddr, wr_en, waddr, wdata,
        input  rdata, rack, raddrerr, wack, waddrerr,
        output grant_id, busy
    );

    modport master (
        output m0_rd_en, m0_wr_en, m0_addr, m0_wdata,
        input  m0_rdata, m0_ack, m0_err,
        output m1_rd_en, m1_wr_en, m1_addr, m1_wdata,
        input  m1_rdata, m1_ack, m1_err,
        input  rd_en, raddr, wr_en, waddr, wdata,
        output rdata, rack, raddrerr, wack, waddrerr,
        input  grant_id, busy
    );
endinterface

// File: rtl/rb_bus_arbiter.sv
// Round-robin two-requester arbiter for the register-block generic bus (IDLE -> ACCESS -> RESP).
// Define RB_ARB_TIMEOUT_EN to add the ACCESS watchdog that force-completes a stuck transfer with an error.
module rb_bus_arbiter #(
    parameter int AW          = 12,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            apb_pclk,
    input  logic            apb_preset,
    rb_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          win_id;
    logic          win_wr;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    logic          req0;
    logic          req1;
    logic          pick;
    logic          pick_wr;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

    logic          done;
    logic          timeout;
    logic          finish;
    logic          fin_err;
    logic [DW-1:0] fin_data;

    // A tie goes to whoever did not win last; a lone request simply wins.
    always_comb begin
        req0       = bus.m0_rd_en | bus.m0_wr_en;
        req1       = bus.m1_rd_en | bus.m1_wr_en;
        pick       = (req0 & req1) ? ~last_grant : req1;
        pick_wr    = pick ? bus.m1_wr_en : bus.m0_wr_en;
        pick_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    // Only the ack matching the granted direction completes; a timeout reports error with zero data.
    always_comb begin
        done   = win_wr ? bus.wack : bus.rack;
        finish = done | timeout;
        if (done) begin
            fin_err  = win_wr ? bus.waddrerr : bus.raddrerr;
            fin_data = win_wr ? '0 : bus.rdata;
        end else begin
            fin_err  = 1'b1;
            fin_data = '0;
        end
    end

`ifdef RB_ARB_TIMEOUT_EN
    localparam int            CW   = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] tcnt;

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            tcnt <= '0;
        end else if (state != ACCESS) begin
            tcnt <= '0;
        end else if (!finish) begin
            tcnt <= tcnt + CW'(1);
        end
    end

    assign timeout = (state == ACCESS) && (tcnt == TMAX);
`else
    logic cfg_unused;

    assign timeout    = 1'b0;
    assign cfg_unused = (TIMEOUT_CYC >= 2);
`endif

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            win_id       <= 1'b0;
            win_wr       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bus.rd_en    <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m0_err   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_ack   <= 1'b0;
            bus.m1_err   <= 1'b0;
            bus.m1_rdata <= '0;
            bus.grant_id <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        win_id       <= pick;
                        win_wr       <= pick_wr;
                        addr_q       <= pick_addr;
                        wdata_q      <= pick_wdata;
                        last_grant   <= pick;
                        bus.grant_id <= pick;
                        bus.wr_en    <= pick_wr;
                        bus.rd_en    <= ~pick_wr;
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        bus.rd_en <= 1'b0;
                        bus.wr_en <= 1'b0;
                        if (win_id) begin
                            bus.m1_ack   <= 1'b1;
                            bus.m1_err   <= fin_err;
                            bus.m1_rdata <= fin_data;
                        end else begin
                            bus.m0_ack   <= 1'b1;
                            bus.m0_err   <= fin_err;
                            bus.m0_rdata <= fin_data;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    // Requests are deliberately not sampled here so a requester releasing on ack is not re-granted.
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.rd_en <= 1'b0;
                    bus.wr_en <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.raddr = addr_q;
    assign bus.waddr = addr_q;
    assign bus.wdata = wdata_q;
endmodule
